// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: widths, fetch FSM states, reset NOP.
package instruction_fetch_unit_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [INSTR_W-1:0] PC_STEP = INSTR_W'(4);

  typedef enum logic [1:0] {
    FETCH_IDLE    = 2'd0,
    FETCH_REQUEST = 2'd1,
    FETCH_WAIT    = 2'd2,
    FETCH_HOLD    = 2'd3
  } fetch_state_e;

  function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] addr);
    return {addr[INSTR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_program_counter.sv
// Program counter: holds the next fetch PC, applies sequential advance and redirects.
module instruction_fetch_unit_program_counter
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_VECTOR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect_enable,
  input  logic [INSTR_W-1:0] redirect_target,
  input  logic               advance,
  input  logic [INSTR_W-1:0] advance_base,
  output logic [INSTR_W-1:0] pc_next_c,
  output logic               misaligned_c
);

  logic [INSTR_W-1:0] pc;

  // Redirect wins over the sequential step; the step wraps modulo 2^32.
  always_comb begin
    pc_next_c = pc;
    if (redirect_enable) begin
      pc_next_c = word_align(redirect_target);
    end else if (advance) begin
      pc_next_c = advance_base + PC_STEP;
    end
  end

  assign misaligned_c = redirect_enable && (redirect_target[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_VECTOR;
    end else begin
      pc <= pc_next_c;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Non-pipelined instruction fetch: one request in flight, redirect with in-flight squash.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [INSTR_W-1:0] NOP_ENCODING = NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               instruction_memory_request_valid,
  input  logic               instruction_memory_request_ready,
  output logic [INSTR_W-1:0] instruction_memory_address,
  input  logic               instruction_memory_response_valid,
  input  logic [INSTR_W-1:0] instruction_memory_response_data,
  output logic [INSTR_W-1:0] instruction_register,
  output logic [INSTR_W-1:0] instruction_pc,
  output logic               instruction_valid,
  input  logic               decode_ready,
  input  logic               redirect_enable,
  input  logic [INSTR_W-1:0] redirect_target,
  output logic               misaligned_fetch_error
);

  fetch_state_e       state;
  fetch_state_e       state_next;
  logic               discard;
  logic               discard_next;
  logic               capture_c;
  logic [INSTR_W-1:0] pc_next_c;
  logic               misaligned_c;

  instruction_fetch_unit_program_counter #(
    .RESET_VECTOR (RESET_VECTOR)
  ) u_program_counter (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_enable (redirect_enable),
    .redirect_target (redirect_target),
    .advance         (capture_c),
    .advance_base    (instruction_memory_address),
    .pc_next_c       (pc_next_c),
    .misaligned_c    (misaligned_c)
  );

  // Next-state and squash bookkeeping; redirect outranks response and decode_ready.
  always_comb begin
    state_next   = state;
    discard_next = discard;
    capture_c    = 1'b0;
    case (state)
      FETCH_IDLE: state_next = FETCH_REQUEST;
      FETCH_REQUEST: begin
        if (redirect_enable) discard_next = 1'b1;
        if (instruction_memory_request_ready) state_next = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (instruction_memory_response_valid) begin
          discard_next = 1'b0;
          if (redirect_enable || discard) begin
            state_next = FETCH_REQUEST;
          end else begin
            state_next = FETCH_HOLD;
            capture_c  = 1'b1;
          end
        end else if (redirect_enable) begin
          discard_next = 1'b1;
        end
      end
      FETCH_HOLD: begin
        if (redirect_enable || decode_ready) state_next = FETCH_REQUEST;
      end
      default: state_next = FETCH_IDLE;
    endcase
  end

  // State plus registered outputs; the fetch address is latched only on entry to REQUEST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                            <= FETCH_IDLE;
      discard                          <= 1'b0;
      instruction_memory_request_valid <= 1'b0;
      instruction_memory_address       <= RESET_VECTOR;
      instruction_register             <= NOP_ENCODING;
      instruction_pc                   <= RESET_VECTOR;
      instruction_valid                <= 1'b0;
      misaligned_fetch_error           <= 1'b0;
    end else begin
      state                            <= state_next;
      discard                          <= discard_next;
      instruction_memory_request_valid <= (state_next == FETCH_REQUEST);
      misaligned_fetch_error           <= misaligned_c;
      if ((state != FETCH_REQUEST) && (state_next == FETCH_REQUEST)) begin
        instruction_memory_address <= pc_next_c;
      end
      if (capture_c) begin
        instruction_register <= instruction_memory_response_data;
        instruction_pc       <= instruction_memory_address;
      end
      if (redirect_enable) begin
        instruction_valid <= 1'b0;
      end else if (capture_c) begin
        instruction_valid <= 1'b1;
      end else if ((state == FETCH_HOLD) && decode_ready) begin
        instruction_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: memory responder, random redirects, reference stream.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] NOP          = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        instruction_memory_request_valid;
  logic        instruction_memory_request_ready;
  logic [31:0] instruction_memory_address;
  logic        instruction_memory_response_valid;
  logic [31:0] instruction_memory_response_data;
  logic [31:0] instruction_register;
  logic [31:0] instruction_pc;
  logic        instruction_valid;
  logic        decode_ready;
  logic        redirect_enable;
  logic [31:0] redirect_target;
  logic        misaligned_fetch_error;

  instruction_fetch_unit #(
    .RESET_VECTOR (RESET_VECTOR),
    .NOP_ENCODING (NOP)
  ) dut (
    .clk                               (clk),
    .rst_n                             (rst_n),
    .instruction_memory_request_valid  (instruction_memory_request_valid),
    .instruction_memory_request_ready  (instruction_memory_request_ready),
    .instruction_memory_address        (instruction_memory_address),
    .instruction_memory_response_valid (instruction_memory_response_valid),
    .instruction_memory_response_data  (instruction_memory_response_data),
    .instruction_register              (instruction_register),
    .instruction_pc                    (instruction_pc),
    .instruction_valid                 (instruction_valid),
    .decode_ready                      (decode_ready),
    .redirect_enable                   (redirect_enable),
    .redirect_target                   (redirect_target),
    .misaligned_fetch_error            (misaligned_fetch_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_deliv  = 0;
  logic [31:0] exp_q[$];

  // Bench controls for the memory responder and decoder.
  int   ready_mode  = 1;  // 0 random, 1 always ready, 2 stalled
  int   lat         = 1;  // 0 random 1..3, else fixed latency
  int   dr_mode     = 1;  // 0 random, 1 always ready, 2 never ready
  bit   mem_hold    = 1'b0;
  bit   stale_pulse = 1'b0;
  int   resp_cnt    = 0;
  logic [31:0] resp_addr;

  // Contents of instruction memory; address 0 holds addi x1,x0,5.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0050_0093 ^ (a * 32'h9E37_79B9);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, 32'(instruction_memory_request_valid), 32'd0);
    check({tag, "_addr"},      instruction_memory_address, RESET_VECTOR);
    check({tag, "_ir"},        instruction_register, NOP);
    check({tag, "_ipc"},       instruction_pc, RESET_VECTOR);
    check({tag, "_valid"},     32'(instruction_valid), 32'd0);
    check({tag, "_err"},       32'(misaligned_fetch_error), 32'd0);
  endtask

  // Redirect for one cycle; the expected stream restarts at the aligned target.
  task automatic do_redirect(input logic [31:0] target, output bit was_req);
    was_req = instruction_memory_request_valid;
    redirect_enable = 1'b1;
    redirect_target = target;
    exp_q.delete();
    exp_q.push_back({target[31:2], 2'b00});
    @(negedge clk);
    redirect_enable = 1'b0;
  endtask

  // Wait for the next fresh request (optionally after the current one is accepted).
  task automatic wait_req(input bit need_low, input string name, input logic [31:0] exp_addr);
    int n = 0;
    if (need_low) begin
      while (instruction_memory_request_valid && n < 100) begin @(negedge clk); n++; end
    end
    while (!instruction_memory_request_valid && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) timeout_fail(name);
    else check(name, instruction_memory_address, exp_addr);
  endtask

  // Memory responder: accepts per ready_mode, answers after lat cycles.
  initial begin
    instruction_memory_request_ready  = 1'b0;
    instruction_memory_response_valid = 1'b0;
    instruction_memory_response_data  = '0;
    forever begin
      @(negedge clk); #1;
      instruction_memory_response_valid = 1'b0;
      if (!rst_n) begin
        resp_cnt = 0;
      end else if (resp_cnt > 0 && !mem_hold) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          instruction_memory_response_valid = 1'b1;
          instruction_memory_response_data  = mem_word(resp_addr);
        end
      end
      if (stale_pulse) begin
        instruction_memory_response_valid = 1'b1;
        instruction_memory_response_data  = 32'hDEAD_BEEF;
      end
      case (ready_mode)
        0:       instruction_memory_request_ready = ($urandom_range(0, 2) != 0);
        1:       instruction_memory_request_ready = 1'b1;
        default: instruction_memory_request_ready = 1'b0;
      endcase
      if (rst_n && instruction_memory_request_valid && instruction_memory_request_ready) begin
        resp_cnt  = (lat == 0) ? int'($urandom_range(1, 3)) : lat;
        resp_addr = instruction_memory_address;
      end
    end
  end

  // Decoder model.
  initial begin
    decode_ready = 1'b0;
    forever begin
      @(negedge clk); #1;
      case (dr_mode)
        1:       decode_ready = 1'b1;
        2:       decode_ready = 1'b0;
        default: decode_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: protocol properties every cycle, delivered instructions against the expected stream.
  initial begin
    logic        prev_valid = 1'b0;
    logic        prev_req   = 1'b0;
    logic [31:0] prev_ir    = '0;
    logic [31:0] prev_pc    = '0;
    logic [31:0] prev_addr  = '0;
    logic [31:0] e;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        prev_valid = 1'b0;
        prev_req   = 1'b0;
        continue;
      end
      check("err_pulse", 32'(misaligned_fetch_error),
            32'(redirect_enable && (redirect_target[1:0] != 2'b00)));
      if (prev_req && !instruction_memory_request_ready) begin
        check("req_held_valid", 32'(instruction_memory_request_valid), 32'd1);
        check("req_held_addr", instruction_memory_address, prev_addr);
      end
      if (instruction_memory_request_valid)
        check("req_aligned", 32'(instruction_memory_address[1:0]), 32'd0);
      if (instruction_valid)
        check("no_req_while_valid", 32'(instruction_memory_request_valid), 32'd0);
      if (prev_valid && redirect_enable)
        check("redirect_kills_valid", 32'(instruction_valid), 32'd0);
      else if (prev_valid && !decode_ready)
        check("valid_held", 32'(instruction_valid), 32'd1);
      if (prev_valid && instruction_valid) begin
        check("ir_stable", instruction_register, prev_ir);
        check("ipc_stable", instruction_pc, prev_pc);
      end
      if (instruction_valid && !prev_valid) begin
        n_deliv++;
        if (exp_q.size() == 0) begin
          timeout_fail("deliver_unexpected");
        end else begin
          e = exp_q.pop_front();
          check("deliver_pc", instruction_pc, e);
          check("deliver_ir", instruction_register, mem_word(e));
          exp_q.push_back(e + 32'd4);
        end
      end
      prev_valid = instruction_valid;
      prev_req   = instruction_memory_request_valid;
      prev_ir    = instruction_register;
      prev_pc    = instruction_pc;
      prev_addr  = instruction_memory_address;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Directed scenarios followed by a randomized run.
  initial begin
    bit          was_req;
    logic [31:0] held_pc;
    logic [31:0] held_ir;
    int          n;
    rst_n           = 1'b0;
    redirect_enable = 1'b0;
    redirect_target = '0;
    exp_q.push_back(RESET_VECTOR);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Straight-line first fetch, k=1.
    @(negedge clk);
    check("t1_req_valid", 32'(instruction_memory_request_valid), 32'd1);
    check("t1_req_addr", instruction_memory_address, 32'h0);
    @(negedge clk);
    check("t1_wait_valid", 32'(instruction_valid), 32'd0);
    @(negedge clk);
    check("t1_valid", 32'(instruction_valid), 32'd1);
    check("t1_ir", instruction_register, 32'h0050_0093);
    check("t1_ipc", instruction_pc, 32'h0);
    @(negedge clk);
    check("t1_next_req", 32'(instruction_memory_request_valid), 32'd1);
    check("t1_next_addr", instruction_memory_address, 32'h4);

    // Decoder stall in HOLD.
    dr_mode = 2;
    n = 0;
    while (!instruction_valid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeout_fail("t2_wait_valid");
    held_pc = instruction_pc;
    held_ir = instruction_register;
    repeat (5) @(negedge clk);
    check("t2_valid", 32'(instruction_valid), 32'd1);
    check("t2_no_req", 32'(instruction_memory_request_valid), 32'd0);
    check("t2_ir", instruction_register, held_ir);
    dr_mode = 1;
    wait_req(1'b0, "t2_next_req", held_pc + 32'd4);

    // Redirect while waiting on a response.
    mem_hold = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (resp_cnt == 0 && n < 50);
    do_redirect(32'h0000_0100, was_req);
    @(negedge clk);
    mem_hold = 1'b0;
    wait_req(was_req, "t3_req", 32'h0000_0100);

    // Misaligned redirect while the request is stalled.
    ready_mode = 2;
    held_pc = instruction_memory_address;
    @(negedge clk);
    do_redirect(32'h0000_0202, was_req);
    check("t4_err_pulse", 32'(misaligned_fetch_error), 32'd1);
    @(negedge clk);
    check("t4_err_clear", 32'(misaligned_fetch_error), 32'd0);
    @(negedge clk);
    check("t4_held_valid", 32'(instruction_memory_request_valid), 32'd1);
    check("t4_held_addr", instruction_memory_address, held_pc);
    ready_mode = 1;
    wait_req(1'b1, "t4_req", 32'h0000_0200);

    // PC wrap at the top of the address space.
    do_redirect(32'hFFFF_FFFC, was_req);
    wait_req(was_req, "t5_req_top", 32'hFFFF_FFFC);
    wait_req(1'b1, "t5_wrap", 32'h0000_0000);

    // Reset mid-fetch; a stray response in IDLE must be ignored.
    mem_hold = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (resp_cnt == 0 && n < 50);
    rst_n = 1'b0;
    exp_q.delete();
    exp_q.push_back(RESET_VECTOR);
    mem_hold = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("t6_reset");
    rst_n = 1'b1;
    stale_pulse = 1'b1;
    @(negedge clk);
    stale_pulse = 1'b0;
    check("t6_req_valid", 32'(instruction_memory_request_valid), 32'd1);
    check("t6_req_addr", instruction_memory_address, RESET_VECTOR);
    check("t6_ir", instruction_register, NOP);
    check("t6_valid", 32'(instruction_valid), 32'd0);

    // Randomized traffic: random ready, latency, decode stalls, redirects, rare resets.
    ready_mode = 0;
    lat        = 0;
    dr_mode    = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        exp_q.delete();
        exp_q.push_back(RESET_VECTOR);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end else if ($urandom_range(0, 14) == 0) begin
        case ($urandom_range(0, 2))
          0:       do_redirect($urandom(), was_req);
          1:       do_redirect(32'hFFFF_FFF0 + 32'($urandom_range(0, 15)), was_req);
          default: do_redirect(32'($urandom_range(0, 255)), was_req);
        endcase
      end
    end
    ready_mode = 1;
    dr_mode    = 1;
    repeat (20) @(negedge clk);
    check("deliveries_min", 32'(n_deliv > 100), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
